if_fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the ID stage and hazard detection.
- Owns the PC and issues requests to a variable-latency instruction memory over a req/ready handshake.
- Presents fetched instructions to ID, and honours freeze from hazard detection and redirect/flush from branch resolution.

---
 rtl/if_fetch_stage_if.sv | 27 ++
 rtl/if_fetch_stage.sv | 132 +++++++++++++
 tb/tb_if_fetch_stage.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request channel plus the IF/ID outputs
// and the hazard/branch control inputs that steer them.
interface if_fetch_stage_if;
  // Handshake: while imem_req=1 the requester holds imem_addr stable; the
  // transfer completes in the cycle imem_ready=1 (possibly the first), and
  // imem_rdata is meaningful only in that cycle.
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;

  modport master (
    input  freeze, branch_taken, branch_addr, imem_rdata, imem_ready,
    output imem_req, imem_addr, id_pc, id_instr, id_valid
  );

  modport slave (
    output freeze, branch_taken, branch_addr, imem_rdata, imem_ready,
    input  imem_req, imem_addr, id_pc, id_instr, id_valid
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch with IF/ID register: owns the PC, talks to a variable-latency
// instruction memory, and applies freeze, flush and redirect from later stages.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_stage_if.master  bus,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] redirect_q, redirect_d;

  logic [31:0] pc_inc;
  logic [31:0] branch_tgt;

  assign pc_inc     = pc_q + 32'd4;
  assign branch_tgt = bus.branch_addr & 32'hFFFF_FFFC;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    buf_d      = buf_q;
    redirect_d = redirect_q;

    unique case (state_q)
      S_FETCH: begin
        if (bus.branch_taken) begin
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
          buf_d      = NOP_INSTR;
          if (bus.imem_ready) begin
            pc_d = branch_tgt;
          end else begin
            // The outstanding request cannot be withdrawn; park the target.
            redirect_d = branch_tgt;
            state_d    = S_DRAIN;
          end
        end else if (bus.imem_ready) begin
          if (bus.freeze) begin
            buf_d   = bus.imem_rdata;
            state_d = S_HOLD;
          end else begin
            id_instr_d = bus.imem_rdata;
            id_pc_d    = pc_inc;
            id_valid_d = 1'b1;
            pc_d       = pc_inc;
          end
        end else if (!bus.freeze) begin
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (bus.branch_taken) begin
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
          buf_d      = NOP_INSTR;
          pc_d       = branch_tgt;
          state_d    = S_FETCH;
        end else if (!bus.freeze) begin
          id_instr_d = buf_q;
          id_pc_d    = pc_inc;
          id_valid_d = 1'b1;
          pc_d       = pc_inc;
          state_d    = S_FETCH;
        end
      end

      S_DRAIN: begin
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
        if (bus.imem_ready) begin
          // A branch arriving with the final beat is younger than the parked one.
          pc_d    = bus.branch_taken ? branch_tgt : redirect_q;
          state_d = S_FETCH;
        end else if (bus.branch_taken) begin
          redirect_d = branch_tgt;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'h0000_0000;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
      buf_q      <= NOP_INSTR;
      redirect_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      buf_q      <= buf_d;
      redirect_q <= redirect_d;
    end
  end

  assign bus.imem_req  = !rst && (state_q != S_HOLD);
  assign bus.imem_addr = pc_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_valid  = id_valid_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Cycle-accurate bench for if_fetch_stage: a wait-state memory model answers
// requests with addr|A000_0000, and each scenario queues per-cycle expectations.
module tb_if_fetch_stage;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         wait_cfg;
  int         mem_cnt;
  int         total;
  int         bad;

  // stimulus: {rst, freeze, branch_taken, branch_addr, wait_cfg[1:0]}
  logic [36:0] stim_q[$];
  // expected: {imem_req, imem_addr, id_valid, id_pc, id_instr, state}
  logic [99:0] exp_q[$];

  if_fetch_stage_if bus ();

  if_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: ready after wait_cfg stalled request cycles
  always_ff @(posedge clk) begin
    if (rst || !bus.imem_req || bus.imem_ready) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
  end
  assign bus.imem_ready = bus.imem_req && (mem_cnt >= wait_cfg);
  assign bus.imem_rdata = bus.imem_addr | 32'hA000_0000;

  function automatic void sched(input logic r, input logic f, input logic b,
                                input logic [31:0] ba, input logic [1:0] w,
                                input logic req, input logic [31:0] addr,
                                input logic v, input logic [31:0] p,
                                input logic [31:0] ins, input logic [1:0] st);
    stim_q.push_back({r, f, b, ba, w});
    exp_q.push_back({req, addr, v, p, ins, st});
  endfunction

  task automatic test_reset();
    logic [36:0] s;
    logic [99:0] got, exp;
    sched(1, 0, 0, 32'h0, 2'd0, 0, 32'h0, 0, 32'h0, 32'h0, 2'd0);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      @(negedge clk);
      {rst, bus.freeze, bus.branch_taken, bus.branch_addr} = s[36:2];
      wait_cfg = int'(s[1:0]);
      #1;
      got = {bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_pc, bus.id_instr, state_dbg};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset got=%h exp=%h", got, exp);
      end
    end
  endtask

  task automatic test_zero_wait();
    logic [36:0] s;
    logic [99:0] got, exp;
    sched(0, 0, 0, 32'h0, 2'd0, 1, 32'h0, 0, 32'h0, 32'h0,        2'd0);
    sched(0, 0, 0, 32'h0, 2'd0, 1, 32'h4, 1, 32'h4, 32'hA000_0000, 2'd0);
    sched(0, 0, 0, 32'h0, 2'd0, 1, 32'h8, 1, 32'h8, 32'hA000_0004, 2'd0);
    sched(0, 0, 0, 32'h0, 2'd0, 1, 32'hC, 1, 32'hC, 32'hA000_0008, 2'd0);
    for (int c = 0; exp_q.size() > 0; c++) begin
      s = stim_q.pop_front();
      @(negedge clk);
      {rst, bus.freeze, bus.branch_taken, bus.branch_addr} = s[36:2];
      wait_cfg = int'(s[1:0]);
      #1;
      got = {bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_pc, bus.id_instr, state_dbg};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL zero_wait cyc=%0d got=%h exp=%h", c, got, exp);
      end
    end
  endtask

  task automatic test_freeze();
    logic [36:0] s;
    logic [99:0] got, exp;
    sched(0, 1, 0, 32'h0, 2'd0, 1, 32'h10, 1, 32'h10, 32'hA000_000C, 2'd0);
    sched(0, 1, 0, 32'h0, 2'd0, 0, 32'h10, 1, 32'h10, 32'hA000_000C, 2'd1);
    sched(0, 1, 0, 32'h0, 2'd0, 0, 32'h10, 1, 32'h10, 32'hA000_000C, 2'd1);
    sched(0, 1, 0, 32'h0, 2'd0, 0, 32'h10, 1, 32'h10, 32'hA000_000C, 2'd1);
    sched(0, 0, 0, 32'h0, 2'd0, 0, 32'h10, 1, 32'h10, 32'hA000_000C, 2'd1);
    sched(0, 0, 0, 32'h0, 2'd0, 1, 32'h14, 1, 32'h14, 32'hA000_0010, 2'd0);
    for (int c = 0; exp_q.size() > 0; c++) begin
      s = stim_q.pop_front();
      @(negedge clk);
      {rst, bus.freeze, bus.branch_taken, bus.branch_addr} = s[36:2];
      wait_cfg = int'(s[1:0]);
      #1;
      got = {bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_pc, bus.id_instr, state_dbg};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL freeze cyc=%0d got=%h exp=%h", c, got, exp);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [36:0] s;
    logic [99:0] got, exp;
    sched(0, 0, 0, 32'h0, 2'd2, 1, 32'h18, 1, 32'h18, 32'hA000_0014, 2'd0);
    sched(0, 0, 0, 32'h0, 2'd2, 1, 32'h18, 0, 32'h18, 32'h0,         2'd0);
    sched(0, 0, 0, 32'h0, 2'd2, 1, 32'h18, 0, 32'h18, 32'h0,         2'd0);
    sched(0, 0, 0, 32'h0, 2'd2, 1, 32'h1C, 1, 32'h1C, 32'hA000_0018, 2'd0);
    sched(0, 0, 0, 32'h0, 2'd2, 1, 32'h1C, 0, 32'h1C, 32'h0,         2'd0);
    sched(0, 0, 0, 32'h0, 2'd2, 1, 32'h1C, 0, 32'h1C, 32'h0,         2'd0);
    for (int c = 0; exp_q.size() > 0; c++) begin
      s = stim_q.pop_front();
      @(negedge clk);
      {rst, bus.freeze, bus.branch_taken, bus.branch_addr} = s[36:2];
      wait_cfg = int'(s[1:0]);
      #1;
      got = {bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_pc, bus.id_instr, state_dbg};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL wait_states cyc=%0d got=%h exp=%h", c, got, exp);
      end
    end
  endtask

  task automatic test_branch_drain();
    logic [36:0] s;
    logic [99:0] got, exp;
    sched(0, 0, 1, 32'h100, 2'd2, 1, 32'h20,  1, 32'h20, 32'hA000_001C, 2'd0);
    sched(0, 1, 0, 32'h0,   2'd2, 1, 32'h20,  0, 32'h20, 32'h0,         2'd2);
    sched(0, 0, 1, 32'h300, 2'd2, 1, 32'h20,  0, 32'h20, 32'h0,         2'd2);
    sched(0, 0, 0, 32'h0,   2'd2, 1, 32'h300, 0, 32'h20, 32'h0,         2'd0);
    sched(0, 0, 0, 32'h0,   2'd2, 1, 32'h300, 0, 32'h20, 32'h0,         2'd0);
    sched(0, 0, 0, 32'h0,   2'd2, 1, 32'h300, 0, 32'h20, 32'h0,         2'd0);
    for (int c = 0; exp_q.size() > 0; c++) begin
      s = stim_q.pop_front();
      @(negedge clk);
      {rst, bus.freeze, bus.branch_taken, bus.branch_addr} = s[36:2];
      wait_cfg = int'(s[1:0]);
      #1;
      got = {bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_pc, bus.id_instr, state_dbg};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL branch_drain cyc=%0d got=%h exp=%h", c, got, exp);
      end
    end
  endtask

  task automatic test_branch_in_hold();
    logic [36:0] s;
    logic [99:0] got, exp;
    sched(0, 1, 0, 32'h0,   2'd0, 1, 32'h304, 1, 32'h304, 32'hA000_0300, 2'd0);
    sched(0, 1, 1, 32'h203, 2'd0, 0, 32'h304, 1, 32'h304, 32'hA000_0300, 2'd1);
    sched(0, 0, 0, 32'h0,   2'd0, 1, 32'h200, 0, 32'h304, 32'h0,         2'd0);
    for (int c = 0; exp_q.size() > 0; c++) begin
      s = stim_q.pop_front();
      @(negedge clk);
      {rst, bus.freeze, bus.branch_taken, bus.branch_addr} = s[36:2];
      wait_cfg = int'(s[1:0]);
      #1;
      got = {bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_pc, bus.id_instr, state_dbg};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL branch_in_hold cyc=%0d got=%h exp=%h", c, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [36:0] s;
    logic [99:0] got, exp;
    sched(0, 0, 1, 32'hFFFF_FFFC, 2'd2, 1, 32'h204, 1, 32'h204, 32'hA000_0200, 2'd0);
    sched(1, 0, 0, 32'h0,         2'd2, 0, 32'h204, 0, 32'h204, 32'h0,         2'd2);
    for (int c = 0; exp_q.size() > 0; c++) begin
      s = stim_q.pop_front();
      @(negedge clk);
      {rst, bus.freeze, bus.branch_taken, bus.branch_addr} = s[36:2];
      wait_cfg = int'(s[1:0]);
      #1;
      got = {bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_pc, bus.id_instr, state_dbg};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_mid_drain cyc=%0d got=%h exp=%h", c, got, exp);
      end
    end
  endtask

  task automatic test_pc_wrap();
    logic [36:0] s;
    logic [99:0] got, exp;
    sched(0, 0, 1, 32'hFFFF_FFFC, 2'd0, 1, 32'h0,         0, 32'h0, 32'h0,         2'd0);
    sched(0, 0, 0, 32'h0,         2'd0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0,         2'd0);
    sched(0, 0, 0, 32'h0,         2'd0, 1, 32'h0,         1, 32'h0, 32'hFFFF_FFFC, 2'd0);
    sched(0, 0, 0, 32'h0,         2'd0, 1, 32'h4,         1, 32'h4, 32'hA000_0000, 2'd0);
    for (int c = 0; exp_q.size() > 0; c++) begin
      s = stim_q.pop_front();
      @(negedge clk);
      {rst, bus.freeze, bus.branch_taken, bus.branch_addr} = s[36:2];
      wait_cfg = int'(s[1:0]);
      #1;
      got = {bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_pc, bus.id_instr, state_dbg};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL pc_wrap cyc=%0d got=%h exp=%h", c, got, exp);
      end
    end
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    wait_cfg         = 0;
    rst              = 1'b1;
    bus.freeze       = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_addr  = 32'h0;
    repeat (2) @(posedge clk);
    test_reset();
    test_zero_wait();
    test_freeze();
    test_wait_states();
    test_branch_drain();
    test_branch_in_hold();
    test_reset_mid_drain();
    test_pc_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
